mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Parametrised N-channel memory request arbiter, the successor to the two-channel load/store arbiter. It accepts read/write requests from NUM_REQ requesters and grants exactly one at a time to the cache/memory port, holding the grant until `done`. Writes take priority over reads, with round-robin fairness within each class. It sits between the requesting pipelines and the cache controller and drives that controller's enable, read/write select and address.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ADDR_W`, default 32: address width per requester.
- `WR_PRIO`, default 1: 1 means any pending write beats any pending read; 0 means single round-robin over all requesters.
- `TIMEOUT_CYCLES`, default 255: watchdog limit in busy cycles. Used only with `ARB_TIMEOUT_EN`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NUM_REQ: per-requester request, level.
- `wr` in NUM_REQ: per-requester operation; 1 = write (store), 0 = read (load).
- `addr_in` in NUM_REQ*ADDR_W: requester i's address is at bits [i*ADDR_W +: ADDR_W].
- `idle` in 1: memory side can accept a new operation.
- `done` in 1: current operation is complete; sampled only while busy.
- `grant` out NUM_REQ: one-hot grant, registered.
- `enable` out 1: memory operation enable, registered.
- `rd_wrt_ca` out 1: 1 = read, 0 = write, registered.
- `addr_out` out ADDR_W: address latched at grant.
- `busy` out 1: a grant is active.
- `timeout_err` out 1: one-cycle watchdog abort pulse.

## Operation
- States are IDLE and BUSY. `busy` = (state == BUSY).
- **Eligibility:** channel i is eligible when `req[i]`=1 and `idle`=1.
- **Winner selection, WR_PRIO=1:** if any eligible channel has `wr`=1, only eligible writers compete; otherwise all eligible readers compete.
- **Winner selection, WR_PRIO=0:** all eligible channels compete.
- **Round-robin:** search starts at `rr_ptr`, ascending with wrap at NUM_REQ-1 to 0. The first hit wins.
- **IDLE:** if a winner w exists, go to BUSY. Set `grant`=1<<w and `enable`=1. Latch `rd_wrt_ca`=~wr[w] and `addr_out`=addr_in[w]. Set `rr_ptr`=(w+1) mod NUM_REQ.
- **BUSY, `done`=0:** hold all outputs. Changes on `req`, `wr`, `addr_in` or `idle` are ignored. A requester dropping `req` does not release its grant.
- **BUSY, `done`=1, winner w exists:** grant w directly, back-to-back, staying in BUSY. Latch w's op and address, and update `rr_ptr`. Selection uses the current-cycle `req` and `idle`, so the finishing channel may win again only if no other channel of its class is eligible.
- **BUSY, `done`=1, no winner:** go to IDLE and clear `grant`, `enable`, `rd_wrt_ca` and `addr_out`.
- **Invariants:** `grant` has at most one bit set. `enable`=|grant.

## Timing
- **Reset:** `rst` high at an edge sets state=IDLE, `rr_ptr`=0, `grant`=0, `enable`=0, `rd_wrt_ca`=0, `addr_out`=0, `busy`=0, `timeout_err`=0 and watchdog count=0. This applies from any state, including mid-operation; no `done` is needed.
- **Grant latency:** 1 cycle. A request eligible at edge t is visible on `grant` after edge t.
- **Minimum operation length:** 1 cycle. `done` sampled at the first busy edge completes the operation.
- **Back-to-back hand-off:** the new grant appears on the edge that samples `done`, with no idle bubble.
- **`done` while IDLE:** ignored.
- **`rr_ptr` update:** only when a grant is issued.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined:** a watchdog counter of width $clog2(TIMEOUT_CYCLES+1) clears on every new grant and increments each BUSY cycle with `done`=0. When it equals TIMEOUT_CYCLES and `done`=0, the next edge goes to IDLE, clears all grant outputs and sets `timeout_err`=1 for exactly one cycle. No back-to-back grant is issued on that edge. If `done`=1 on the same edge, the edge is a normal completion and `timeout_err` stays 0.
- **Undefined:** no counter is built, `timeout_err` is tied to 0, and BUSY waits indefinitely for `done`.

## Test plan
- **Reset and single read:** reset; `req`=4'b0100, `wr`=0, `idle`=1, addr[2]=0x40 -> one edge later `grant`=4'b0100, `enable`=1, `rd_wrt_ca`=1, `addr_out`=0x40. `done` pulse -> all outputs 0 and `busy`=0.
- **Write priority:** `req`=4'b0011 with `wr`=4'b0010 -> `grant`=4'b0010 and `rd_wrt_ca`=0. After its `done`, with `req`=4'b0001 -> `grant`=4'b0001 back-to-back on the `done` edge.
- **Round-robin:** all four request reads continuously, `done` every 3rd cycle -> grant order 0,1,2,3,0. No channel is granted twice before the others are served.
- **Hold and ignore:** in BUSY, drop `req`, change `addr_in` and drop `idle` -> `grant` and `addr_out` are unchanged until `done`.
- **Reset mid-operation:** `rst` high while BUSY -> all outputs 0 at the next edge. With `req`=4'b1000 after reset -> `grant`=4'b1000 (`rr_ptr` restarts at 0).
- **Watchdog (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4):** grant with no `done` -> after 4 BUSY cycles `grant` clears and `timeout_err` is high for 1 cycle. Repeat with `done` on the limit cycle -> `timeout_err` stays 0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// N-channel memory request arbiter: writes beat reads, round-robin within each class.
// Grant latency: 1 cycle. Back-to-back hand-off happens on the edge that samples done.
// Requesters wait while a grant is held; an optional watchdog (ARB_TIMEOUT_EN) aborts hung operations.
module mem_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int WR_PRIO        = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wr,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  input  logic                      idle,
  input  logic                      done,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      enable,
  output logic                      rd_wrt_ca,
  output logic [ADDR_W-1:0]         addr_out,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t               state, state_next;
  logic [PTR_W-1:0]     rr_ptr, rr_next;
  logic [NUM_REQ-1:0]   grant_next;
  logic                 enable_next;
  logic                 rd_next;
  logic [ADDR_W-1:0]    addr_next;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   wr_elig;
  logic [NUM_REQ-1:0]   cand;
  logic                 win_vld;
  logic [PTR_W-1:0]     win_idx;
  logic                 timeout_hit;

  assign eligible = req & {NUM_REQ{idle}};
  assign wr_elig  = eligible & wr;
  // With write priority, any eligible writer shuts out every reader this round.
  assign cand     = ((WR_PRIO != 0) && (|wr_elig)) ? wr_elig : eligible;
  assign busy     = (state == ST_BUSY);

  // Round-robin search over candidates, starting at rr_ptr and wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign timeout_hit = busy && !done && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  // Watchdog: cleared on each new grant or abort, counts busy cycles without done.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (!busy || done || timeout_hit) wd_cnt <= '0;
      else                              wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and next-output logic; outputs hold unless a grant is issued or released.
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    enable_next = enable;
    rd_next     = rd_wrt_ca;
    addr_next   = addr_out;
    rr_next     = rr_ptr;
    if ((state == ST_IDLE || done) && !timeout_hit && win_vld) begin
      state_next  = ST_BUSY;
      grant_next  = NUM_REQ'(1) << win_idx;
      enable_next = 1'b1;
      rd_next     = ~wr[win_idx];
      addr_next   = addr_in[win_idx*ADDR_W +: ADDR_W];
      rr_next     = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end else if (state == ST_BUSY && (done || timeout_hit)) begin
      state_next  = ST_IDLE;
      grant_next  = '0;
      enable_next = 1'b0;
      rd_next     = 1'b0;
      addr_next   = '0;
    end
  end

  // State, pointer and registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      enable    <= 1'b0;
      rd_wrt_ca <= 1'b0;
      addr_out  <= '0;
    end else begin
      state     <= state_next;
      rr_ptr    <= rr_next;
      grant     <= grant_next;
      enable    <= enable_next;
      rd_wrt_ca <= rd_next;
      addr_out  <= addr_next;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are checked at that point.
// Each step either holds or advances by whole clock cycles.
module tb_mem_req_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   wr;
  logic [127:0] addr_in;
  logic         idle;
  logic         done;
  logic [3:0]   grant;
  logic         enable;
  logic         rd_wrt_ca;
  logic [31:0]  addr_out;
  logic         busy;
  logic         timeout_err;

  int total  = 0;
  int passed = 0;

  mem_req_arbiter #(
    .NUM_REQ(4), .ADDR_W(32), .WR_PRIO(1), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr_in(addr_in),
    .idle(idle), .done(done), .grant(grant), .enable(enable),
    .rd_wrt_ca(rd_wrt_ca), .addr_out(addr_out), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic rd,
                           input logic [31:0] a);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".enable"}, 32'(enable), 32'(|g));
    chk({tag, ".busy"}, 32'(busy), 32'(|g));
    chk({tag, ".rd_wrt_ca"}, 32'(rd_wrt_ca), 32'(rd));
    chk({tag, ".addr_out"}, addr_out, a);
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic set_addr(input int i, input logic [31:0] v);
    addr_in[i*32 +: 32] = v;
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1; req = '0; wr = '0; addr_in = '0; idle = 1'b1; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_out("reset", 4'b0000, 1'b0, 32'h0);

    // Single read on channel 2.
    set_addr(2, 32'h40);
    req = 4'b0100;
    tick();
    check_out("rd1", 4'b0100, 1'b1, 32'h40);
    req = '0; done = 1'b1;
    tick();
    check_out("rd1_done", 4'b0000, 1'b0, 32'h0);
    // done while idle is ignored.
    tick();
    done = 1'b0;
    check_out("done_idle", 4'b0000, 1'b0, 32'h0);

    // Write priority, then back-to-back hand-off to a reader.
    set_addr(0, 32'h100); set_addr(1, 32'h200);
    req = 4'b0011; wr = 4'b0010;
    tick();
    check_out("wprio", 4'b0010, 1'b0, 32'h200);
    req = 4'b0001; wr = 4'b0000; done = 1'b1;
    tick();
    check_out("b2b", 4'b0001, 1'b1, 32'h100);
    req = '0;
    tick();
    done = 1'b0;
    check_out("b2b_done", 4'b0000, 1'b0, 32'h0);

    // Round-robin from a fresh pointer: 0,1,2,3,0 with done every third cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, 32'h1000 + 32'(i));
    req = 4'b1111; wr = 4'b0000;
    tick();
    check_out("rr_first", rr_exp[0], 1'b1, 32'h1000);
    for (int k = 0; k < 4; k++) begin
      tick(); tick();
      chk($sformatf("rr_hold%0d", k), 32'(grant), 32'(rr_exp[k]));
      done = 1'b1;
      tick();
      done = 1'b0;
      chk($sformatf("rr_next%0d", k), 32'(grant), 32'(rr_exp[k+1]));
      chk($sformatf("rr_addr%0d", k), addr_out, 32'h1000 + 32'((k + 1) % 4));
    end
    req = '0; done = 1'b1;
    tick();
    done = 1'b0;
    check_out("rr_done", 4'b0000, 1'b0, 32'h0);

    // Hold while busy: input changes are ignored until done.
    set_addr(2, 32'h300);
    req = 4'b0100; wr = 4'b0100;
    tick();
    check_out("hold_grant", 4'b0100, 1'b0, 32'h300);
    req = '0; wr = '0; idle = 1'b0; set_addr(2, 32'hdead);
    tick(); tick();
    check_out("hold_kept", 4'b0100, 1'b0, 32'h300);
    idle = 1'b1; done = 1'b1;
    tick();
    done = 1'b0;
    check_out("hold_done", 4'b0000, 1'b0, 32'h0);

    // Reset mid-operation, and the pointer restarts at 0.
    req = 4'b0010;
    tick();
    check_out("mid_grant", 4'b0010, 1'b1, 32'h1001);
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    check_out("mid_reset", 4'b0000, 1'b0, 32'h0);
    req = 4'b1000;
    tick();
    check_out("post_reset", 4'b1000, 1'b1, 32'h1003);
    req = '0; done = 1'b1;
    tick();
    done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1010;
    tick();
    chk("rr_restart", 32'(grant), 32'(4'b0010));
    req = '0; done = 1'b1;
    tick();
    done = 1'b0;
    check_out("restart_done", 4'b0000, 1'b0, 32'h0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog abort, then a completion landing on the limit cycle.
    req = 4'b0001;
    tick();
    req = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("wd_busy%0d", k), 32'(grant), 32'(4'b0001));
    end
    tick();
    chk("wd_grant_clr", 32'(grant), 32'd0);
    chk("wd_err", 32'(timeout_err), 32'd1);
    tick();
    chk("wd_err_pulse", 32'(timeout_err), 32'd0);
    req = 4'b0001;
    tick();
    req = '0;
    tick(); tick(); tick(); tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check_out("wd_done_limit", 4'b0000, 1'b0, 32'h0);
    tick();
    chk("wd_no_err", 32'(timeout_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
